// File: rtl/vram_byte_initiator_if.sv
// Request/response handshake and VRAM word-bus signals of vram_byte_initiator.
// req_nibsel exists only when VRAM_NIBBLE_WRITE_EN is defined.
interface vram_byte_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [16:0] req_addr;
    logic [7:0]  req_wrdata;
`ifdef VRAM_NIBBLE_WRITE_EN
    logic [1:0]  req_nibsel;
`endif
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rddata;
    logic [14:0] bus_addr;
    logic [31:0] bus_wrdata;
    logic [7:0]  bus_wrnibblesel;
    logic        bus_write;
    logic [31:0] bus_rddata;

    modport master (
`ifdef VRAM_NIBBLE_WRITE_EN
        input  req_nibsel,
`endif
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wrdata,
        output req_ready,
        output rsp_valid,
        input  rsp_ready,
        output rsp_rddata,
        output bus_addr,
        output bus_wrdata,
        output bus_wrnibblesel,
        output bus_write,
        input  bus_rddata
    );

    modport slave (
`ifdef VRAM_NIBBLE_WRITE_EN
        output req_nibsel,
`endif
        output req_valid,
        output req_write,
        output req_addr,
        output req_wrdata,
        input  req_ready,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_rddata,
        input  bus_addr,
        input  bus_wrdata,
        input  bus_wrnibblesel,
        input  bus_write,
        output bus_rddata
    );
endinterface

// File: rtl/vram_byte_initiator.sv
// Byte-request to 32-bit VRAM word-bus initiator with in-order, credit-limited read responses.
// Define VRAM_NIBBLE_WRITE_EN to enable single-nibble writes via req_nibsel.
module vram_byte_initiator #(
    parameter int unsigned RSP_DEPTH = 4
) (
    input logic                   clk,
    input logic                   rst,
    vram_byte_initiator_if.master bus_if
);
    localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(RSP_DEPTH);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

    logic [14:0]     bus_addr_q, bus_addr_d;
    logic [31:0]     bus_wrdata_q, bus_wrdata_d;
    logic [7:0]      bus_nib_q, bus_nib_d;
    logic            bus_write_q, bus_write_d;
    logic            rd1_q, rd1_d, rd2_q;
    logic [1:0]      lane1_q, lane1_d, lane2_q;
    logic [CntW-1:0] credit_q, credit_d, fill_q, fill_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]      fifo_q [RSP_DEPTH];

    logic       req_ready, rsp_valid;
    logic       accept, rd_accept, wr_accept, push, pop;
    logic [1:0] lane;
    logic [7:0] wr_nib, push_byte;
`ifdef VRAM_NIBBLE_WRITE_EN
    logic [1:0] nib_pair;
`endif

    assign req_ready = credit_q < CntMax;
    assign rsp_valid = fill_q != '0;

    always_comb begin
        lane      = bus_if.req_addr[1:0];
        accept    = bus_if.req_valid && req_ready;
        rd_accept = accept && !bus_if.req_write;
        wr_accept = accept && bus_if.req_write;
`ifdef VRAM_NIBBLE_WRITE_EN
        case (bus_if.req_nibsel)
            2'b01:   nib_pair = 2'b01;
            2'b10:   nib_pair = 2'b10;
            default: nib_pair = 2'b11;
        endcase
        wr_nib = {6'b0, nib_pair} << {lane, 1'b0};
`else
        wr_nib = 8'h03 << {lane, 1'b0};
`endif
        bus_addr_d   = accept ? bus_if.req_addr[16:2] : bus_addr_q;
        bus_wrdata_d = wr_accept ? {4{bus_if.req_wrdata}} : bus_wrdata_q;
        bus_nib_d    = wr_accept ? wr_nib : 8'h00;
        bus_write_d  = wr_accept;
        rd1_d        = rd_accept;
        lane1_d      = lane;

        // Read data belongs to the address presented two edges ago.
        case (lane2_q)
            2'd0:    push_byte = bus_if.bus_rddata[7:0];
            2'd1:    push_byte = bus_if.bus_rddata[15:8];
            2'd2:    push_byte = bus_if.bus_rddata[23:16];
            default: push_byte = bus_if.bus_rddata[31:24];
        endcase
        push = rd2_q;
        pop  = rsp_valid && bus_if.rsp_ready;

        case ({rd_accept, pop})
            2'b10:   credit_d = credit_q + CntOne;
            2'b01:   credit_d = credit_q - CntOne;
            default: credit_d = credit_q;
        endcase
        case ({push, pop})
            2'b10:   fill_d = fill_q + CntOne;
            2'b01:   fill_d = fill_q - CntOne;
            default: fill_d = fill_q;
        endcase
        wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_addr_q   <= '0;
            bus_wrdata_q <= '0;
            bus_nib_q    <= '0;
            bus_write_q  <= 1'b0;
            rd1_q        <= 1'b0;
            rd2_q        <= 1'b0;
            lane1_q      <= '0;
            lane2_q      <= '0;
            credit_q     <= '0;
            fill_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            bus_addr_q   <= bus_addr_d;
            bus_wrdata_q <= bus_wrdata_d;
            bus_nib_q    <= bus_nib_d;
            bus_write_q  <= bus_write_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd1_q;
            lane1_q      <= lane1_d;
            lane2_q      <= lane1_q;
            credit_q     <= credit_d;
            fill_q       <= fill_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible while fill_q is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_byte;
        end
    end

    assign bus_if.req_ready       = req_ready;
    assign bus_if.rsp_valid       = rsp_valid;
    assign bus_if.rsp_rddata      = rsp_valid ? fifo_q[rd_ptr_q] : 8'h00;
    assign bus_if.bus_addr        = bus_addr_q;
    assign bus_if.bus_wrdata      = bus_wrdata_q;
    assign bus_if.bus_wrnibblesel = bus_nib_q;
    assign bus_if.bus_write       = bus_write_q;
endmodule
